// File: rtl/dbus_sram_responder.sv
// Data-bus responder: captures one request, waits LATENCY cycles, then completes it
// against an internal 64-bit SRAM with byte-strobed writes and access-error detection.
module dbus_sram_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned WORDS   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [31:0] txn_count
);

  localparam int IW = $clog2(WORDS);
  localparam logic [64:0] WIN_LO = {1'b0, BASE};
  localparam logic [64:0] WIN_HI = {1'b0, BASE} + 65'(WORDS) * 65'd8 - 65'd1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    strb_q, strb_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [31:0]   txn_q, txn_d;

  logic [63:0]   mem [WORDS];

  logic [63:0]   cur_addr;
  logic [2:0]    cur_size;
  logic [7:0]    cur_strb;
  logic [64:0]   a65;
  logic          out_win;
  logic [2:0]    amask;
  logic [2:0]    lo;
  logic [3:0]    nb;
  logic [7:0]    lanes;
  logic          cur_err;
  logic [IW-1:0] cur_idx;
  logic          go_resp;

  // While idle the live request is decoded so LATENCY=0 can read the SRAM on the
  // capture edge; afterwards only the latched copy matters.
  always_comb begin
    cur_addr = (state_q == S_IDLE) ? req_addr   : addr_q;
    cur_size = (state_q == S_IDLE) ? req_size   : size_q;
    cur_strb = (state_q == S_IDLE) ? req_strobe : strb_q;
    a65      = {1'b0, cur_addr};
    out_win  = (a65 < WIN_LO) || (a65 > WIN_HI);
    case (cur_size)
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      3'd3:    amask = 3'b111;
      default: amask = 3'b000;
    endcase
    lo    = cur_addr[2:0];
    nb    = 4'd1 << cur_size[1:0];
    lanes = '0;
    for (int i = 0; i < 8; i++)
      lanes[i] = (4'(i) >= {1'b0, lo}) && (4'(i) < ({1'b0, lo} + nb));
    cur_err = out_win || (cur_size > 3'd3) || (|(lo & amask)) || (|(cur_strb & ~lanes));
    cur_idx = IW'((cur_addr - BASE) >> 3);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    strb_d  = strb_q;
    data_d  = data_q;
    rdata_d = '0;
    txn_d   = txn_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          strb_d = req_strobe;
          data_d = req_data;
          cnt_d  = 8'(LATENCY);
          if (LATENCY == 0) go_resp = 1'b1;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) go_resp = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        txn_d   = txn_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      state_d = S_RESP;
      if (!cur_err && cur_strb == 8'd0) rdata_d = mem[cur_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      txn_q   <= txn_d;
    end
  end

  // SRAM is not reset; a reset that lands before this edge leaves state_q idle, so nothing commits.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && !cur_err && strb_q != 8'd0) begin
      for (int i = 0; i < 8; i++)
        if (strb_q[i]) mem[cur_idx][8*i +: 8] <= data_q[8*i +: 8];
    end
  end

  assign resp_data_ok = (state_q == S_RESP);
  assign resp_addr_ok = (state_q == S_RESP);
  assign resp_err     = (state_q == S_RESP) && cur_err;
  assign resp_data    = rdata_q;
  assign txn_count    = txn_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: directed scenarios plus randomized traffic against a
// word-array reference model; a second LATENCY=0 instance covers back-to-back timing.
module tb_dbus_sram_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr, req_data;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic        resp_addr_ok, resp_data_ok, resp_err;
  logic [63:0] resp_data;
  logic [31:0] txn_count;

  logic        z_valid;
  logic [63:0] z_addr, z_data;
  logic [2:0]  z_size;
  logic [7:0]  z_strobe;
  logic        z_addr_ok, z_data_ok, z_err;
  logic [63:0] z_rdata;
  logic [31:0] z_count;

  dbus_sram_responder #(.BASE(BASE), .WORDS(WORDS), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok), .resp_data(resp_data),
    .resp_err(resp_err), .txn_count(txn_count));

  dbus_sram_responder #(.BASE(BASE), .WORDS(WORDS), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_addr(z_addr),
    .req_size(z_size), .req_strobe(z_strobe), .req_data(z_data),
    .resp_addr_ok(z_addr_ok), .resp_data_ok(z_data_ok), .resp_data(z_rdata),
    .resp_err(z_err), .txn_count(z_count));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] mdl [16];
  int unsigned exp_txn = 0;

  function automatic logic ref_err(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st);
    longint unsigned nbytes, lo;
    if (a < BASE || a >= BASE + 64'(WORDS) * 8) return 1'b1;
    if (sz > 3) return 1'b1;
    nbytes = 64'd1 << sz;
    if (a % nbytes != 0) return 1'b1;
    lo = a % 8;
    for (int i = 0; i < 8; i++)
      if (st[i] && (i < lo || i >= lo + nbytes)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: decide outcome from the access rules, then apply any write to the model.
  task automatic model_txn(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                           input logic [63:0] d, output logic [63:0] ed, output logic ee);
    int idx;
    ee = ref_err(a, sz, st);
    ed = '0;
    exp_txn++;
    if (ee) return;
    idx = int'((a - BASE) / 8);
    if (st == 8'd0) ed = mdl[idx];
    else for (int i = 0; i < 8; i++) if (st[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  // Drives one request on the LATENCY=2 instance; called just after a rising edge in IDLE.
  task automatic txn(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                     input logic [63:0] d, output logic [63:0] rd, output logic er,
                     output logic aok, output int cyc);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_strobe = st; req_data = d;
    cyc = -1; rd = '0; er = 1'b0; aok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_data_ok) begin
        cyc = k; rd = resp_data; er = resp_err; aok = resp_addr_ok;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic z_txn(input logic [63:0] a, input logic [7:0] st, input logic [63:0] d,
                       output int cyc);
    z_valid = 1'b1; z_addr = a; z_size = 3'd3; z_strobe = st; z_data = d;
    cyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (z_data_ok) begin cyc = k; break; end
    end
    @(posedge clk); #1;
    z_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (resp_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok got=%b want=0", resp_data_ok); end
    n_tests++; if (resp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok got=%b want=0", resp_addr_ok); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", resp_err); end
    n_tests++; if (resp_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", resp_data); end
    n_tests++; if (txn_count !== 32'd0) begin n_fail++; $display("FAIL reset_txn got=%0d want=0", txn_count); end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_txn = 0;
  endtask

  task automatic test_round_trip;
    logic [63:0] rd, ed; logic er, ee, aok; int cyc;
    model_txn(64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, ed, ee);
    txn(64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, rd, er, aok, cyc);
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL rt_wr_latency got=%0d want=3", cyc); end
    n_tests++; if (er !== 1'b0 || rd !== 64'd0) begin n_fail++; $display("FAIL rt_wr_resp err=%b data=%h want err=0 data=0", er, rd); end
    n_tests++; if (aok !== 1'b1) begin n_fail++; $display("FAIL rt_addr_ok got=%b want=1", aok); end
    model_txn(64'h8000_0008, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(64'h8000_0008, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (rd !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL rt_rd_data got=%h want=1122334455667788", rd); end
    n_tests++; if (cyc !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL rt_rd_resp cyc=%0d err=%b want 3/0", cyc, er); end
    n_tests++; if (txn_count !== 32'd2) begin n_fail++; $display("FAIL rt_txn got=%0d want=2", txn_count); end
  endtask

  task automatic test_byte_lane;
    logic [63:0] rd, ed; logic er, ee, aok; int cyc;
    model_txn(64'h8000_0010, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, ed, ee);
    txn(64'h8000_0010, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, aok, cyc);
    model_txn(64'h8000_0012, 3'd1, 8'h0C, 64'h0000_0000_ABCD_0000, ed, ee);
    txn(64'h8000_0012, 3'd1, 8'h0C, 64'h0000_0000_ABCD_0000, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b0 || cyc !== 3) begin n_fail++; $display("FAIL lane_wr err=%b cyc=%0d want 0/3", er, cyc); end
    model_txn(64'h8000_0010, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (rd !== 64'hFFFF_FFFF_ABCD_FFFF) begin n_fail++; $display("FAIL lane_rd got=%h want=ffffffffabcdffff", rd); end
  endtask

  task automatic test_errors;
    logic [63:0] rd, ed; logic er, ee, aok; int cyc;
    model_txn(64'h8000_0000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, ed, ee);
    txn(64'h8000_0000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, er, aok, cyc);
    model_txn(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_below err=%b data=%h want 1/0", er, rd); end
    model_txn(64'h8000_0002, 3'd2, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, ed, ee);
    txn(64'h8000_0002, 3'd2, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b1 || cyc !== 3) begin n_fail++; $display("FAIL err_misalign err=%b cyc=%0d want 1/3", er, cyc); end
    model_txn(64'h8000_0000, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(64'h8000_0000, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL err_nowrite got=%h want=0123456789abcdef", rd); end
    model_txn(BASE + 64'(WORDS) * 8, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(BASE + 64'(WORDS) * 8, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_above err=%b data=%h want 1/0", er, rd); end
    model_txn(BASE + 64'(WORDS) * 8 - 8, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(BASE + 64'(WORDS) * 8 - 8, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_lastword err=%b want 0", er); end
    model_txn(64'h8000_0008, 3'd5, 8'h00, 64'd0, ed, ee);
    txn(64'h8000_0008, 3'd5, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL err_size err=%b data=%h want 1/0", er, rd); end
  endtask

  // Fields change and valid drops right after capture; the latched read must complete.
  task automatic test_protocol;
    logic [63:0] ed, rd; logic ee, er; int cyc;
    model_txn(64'h8000_0008, 3'd3, 8'h00, 64'd0, ed, ee);
    req_valid = 1'b1; req_addr = 64'h8000_0008; req_size = 3'd3; req_strobe = 8'h00; req_data = '0;
    cyc = -1; rd = '0; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_data_ok) begin cyc = k; rd = resp_data; er = resp_err; end
      @(posedge clk); #1;
      if (k == 0) begin
        req_valid = 1'b0; req_addr = 64'h8000_0010; req_strobe = 8'hFF; req_data = '0;
      end
      if (cyc >= 0) break;
    end
    req_strobe = 8'h00;
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL proto_latency got=%0d want=3", cyc); end
    n_tests++; if (rd !== ed || er !== ee) begin n_fail++; $display("FAIL proto_data got=%h/%b want=%h/%b", rd, er, ed, ee); end
    begin
      logic aok;
      model_txn(64'h8000_0010, 3'd3, 8'h00, 64'd0, ed, ee);
      txn(64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
      n_tests++; if (rd !== ed) begin n_fail++; $display("FAIL proto_nowrite got=%h want=%h", rd, ed); end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd, ed; logic er, ee, aok; int cyc; int seen;
    model_txn(64'h8000_0020, 3'd3, 8'hFF, 64'hDEAD_BEEF_0123_4567, ed, ee);
    txn(64'h8000_0020, 3'd3, 8'hFF, 64'hDEAD_BEEF_0123_4567, rd, er, aok, cyc);
    req_valid = 1'b1; req_addr = 64'h8000_0020; req_size = 3'd3; req_strobe = 8'hFF; req_data = 64'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++; if (txn_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_txn got=%0d want=0", txn_count); end
    n_tests++; if (resp_data_ok !== 1'b0 || resp_err !== 1'b0 || resp_data !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_out ok=%b err=%b data=%h want 0", resp_data_ok, resp_err, resp_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_txn = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_data_ok) seen++; end
    @(posedge clk); #1;
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_ok got=%0d want=0", seen); end
    n_tests++; if (txn_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_txn_after got=%0d want=0", txn_count); end
    model_txn(64'h8000_0020, 3'd3, 8'h00, 64'd0, ed, ee);
    txn(64'h8000_0020, 3'd3, 8'h00, 64'd0, rd, er, aok, cyc);
    n_tests++; if (rd !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL rstmid_rd got=%h want=deadbeef01234567", rd); end
    n_tests++; if (txn_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_txn_rd got=%0d want=1", txn_count); end
  endtask

  task automatic test_random;
    logic [63:0] a, d, rd, ed; logic [2:0] sz; logic [7:0] st, mask; logic er, ee, aok;
    int cyc, r, lo, nbytes;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 4));
      d  = {$urandom, $urandom};
      if (r == 0)      a = BASE - 64'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 64'(WORDS) * 8 + 64'($urandom_range(0, 15));
      else begin
        a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
        if (sz <= 3 && $urandom_range(0, 4) != 0) a = a & ~((64'd1 << sz) - 1);
      end
      lo = int'(a % 8); nbytes = (sz <= 3) ? (1 << sz) : 0;
      mask = '0;
      for (int i = 0; i < 8; i++) if (i >= lo && i < lo + nbytes) mask[i] = 1'b1;
      case ($urandom_range(0, 3))
        0, 1:    st = 8'h00;
        2:       begin st = mask & 8'($urandom); if (st == 8'h00) st = mask; end
        default: st = 8'($urandom);
      endcase
      model_txn(a, sz, st, d, ed, ee);
      txn(a, sz, st, d, rd, er, aok, cyc);
      n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d want=3", n, cyc); end
      n_tests++; if (er !== ee || rd !== ed) begin
        n_fail++; $display("FAIL rnd%0d_resp a=%h sz=%0d st=%h got=%h/%b want=%h/%b", n, a, sz, st, rd, er, ed, ee); end
      n_tests++; if (txn_count !== exp_txn) begin n_fail++; $display("FAIL rnd%0d_txn got=%0d want=%0d", n, txn_count, exp_txn); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] zval [4];
    logic [63:0] pres [16];
    logic exp_ok;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      zval[i] = {$urandom, $urandom};
      z_txn(BASE + 64'(i) * 8, 8'hFF, zval[i], cyc);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL b2b_wr%0d_latency got=%0d want=1", i, cyc); end
    end
    z_valid = 1'b1; z_size = 3'd3; z_strobe = 8'h00; z_data = '0;
    for (int k = 0; k < 16; k++) begin
      z_addr  = BASE + 64'($urandom_range(0, 3)) * 8;
      pres[k] = z_addr;
      @(negedge clk);
      exp_ok = (k % 2 == 1);
      n_tests++; if (z_data_ok !== exp_ok) begin n_fail++; $display("FAIL b2b_ok%0d got=%b want=%b", k, z_data_ok, exp_ok); end
      if (k % 2 == 1) begin
        n_tests++; if (z_rdata !== zval[int'((pres[k-1] - BASE) / 8)] || z_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data%0d got=%h want=%h", k, z_rdata, zval[int'((pres[k-1] - BASE) / 8)]); end
      end
      @(posedge clk); #1;
    end
    z_valid = 1'b0;
    n_tests++; if (z_count !== 32'd12) begin n_fail++; $display("FAIL b2b_txn got=%0d want=12", z_count); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_strobe = '0; req_data = '0;
    z_valid = 1'b0; z_addr = '0; z_size = '0; z_strobe = '0; z_data = '0;
    test_reset;
    test_round_trip;
    test_byte_lane;
    test_errors;
    test_protocol;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Responder end of the core's data-bus request/response handshake. It accepts one dbus request at a time, holds it for a configurable number of wait states, and completes it against an internal 64-bit-wide SRAM model with byte-strobed writes. It also flags out-of-window and misaligned accesses. It sits between the core's `dreq`/`dresp` ports and the simulation top, replacing the external memory model for directed tests and wait-state stress.

## Interface
- `BASE`, 64'h8000_0000: byte address of SRAM word 0.
- `WORDS`, 4096: SRAM depth in 64-bit words. Must be a power of two, ≥2.
- `LATENCY`, 2: wait-state cycles inserted between request capture and response, 0..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present; initiator holds it and all request fields stable until `resp_data_ok`.
- `req_addr`  in  64  byte address.
- `req_size`  in  3  log2 access bytes: 0=1, 1=2, 2=4, 3=8. Values 4..7 are illegal.
- `req_strobe`  in  8  write byte-lane enables. All zero means read.
- `req_data`  in  64  write data, lane-aligned to `req_addr[2:0]` by the initiator.
- `resp_addr_ok`  out  1  request accepted; pulses together with `resp_data_ok`.
- `resp_data_ok`  out  1  one-cycle completion pulse.
- `resp_data`  out  64  full aligned SRAM word for reads; 0 for writes and errors.
- `resp_err`  out  1  one-cycle pulse with `resp_data_ok` when the access is erroneous.
- `txn_count`  out  32  number of completed transactions, including errored ones; wraps at 2^32.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `req_valid`=1, latch addr, size, strobe and data.
  - Load `cnt` with `LATENCY`.
  - Go to WAIT if `LATENCY`>0, else RESP.
- **WAIT**
  - `cnt` decrements each cycle.
  - When `cnt`==1, go to RESP.
- **RESP**
  - Drive `resp_addr_ok`=`resp_data_ok`=1 for exactly one cycle.
  - Increment `txn_count`.
  - Always go to IDLE next cycle.
- All behaviour after capture uses the latched copy. If `req_valid` drops or the fields change mid-transaction (a protocol violation), the transaction still completes unchanged.
- Index = (addr − `BASE`) >> 3, width log2(`WORDS`).
- An access is in-window when `BASE` ≤ addr and addr ≤ `BASE` + `WORDS`·8 − 1. Compute with 65-bit arithmetic so `BASE` + size does not wrap.
- Error conditions (any one makes the access erroneous):
  - out-of-window address;
  - `req_size` > 3;
  - addr not aligned to 2^size;
  - `req_strobe` has bits outside the lanes covered by addr[2:0] and size.
- Error response: `resp_err`=1, `resp_data`=0, no SRAM write.
- **Read** (strobe==0, no error): `resp_data` = SRAM[index], the whole word, registered so it is valid in the RESP cycle.
- **Write** (strobe≠0, no error):
  - For each lane i with strobe[i]=1, SRAM[index] byte i ← `req_data` byte i.
  - The write commits at the clock edge ending the RESP cycle; unstrobed bytes are unchanged.
  - `resp_data`=0.
- SRAM contents are not affected by `reset`. The simulation model initialises them to 0 at time zero.

## Timing
- Reset (`reset`=0, asynchronous): FSM→IDLE, `cnt`=0, and all outputs 0, including `txn_count`.
- Reset during WAIT or RESP abandons the transaction: no write commits and no `data_ok` is produced.
- Request first seen in IDLE at cycle t → `resp_data_ok` at cycle t+1+`LATENCY`.
  - With `LATENCY`=0, the response arrives the cycle after capture.
- The cycle after RESP is always IDLE. A request held there, or a new one, is captured in that cycle.
  - Minimum spacing between completions is 2+`LATENCY` cycles.
- `req_valid` is ignored outside IDLE.
- Read-after-write to the same word: the write commits at the end of its RESP cycle, so a read captured in the following IDLE cycle returns the new data.
- `txn_count` increments on the edge ending RESP, so its new value is visible the cycle after `data_ok`.

## Test plan
- **Read/write round trip** (`LATENCY`=2): write addr 0x8000_0008, strobe 0xFF, data 0x1122_3344_5566_7788 → `data_ok` 3 cycles after capture, `resp_err`=0. Then read the same address → `resp_data`=0x1122_3344_5566_7788, `txn_count`=2.
- **Byte-lane write:** preload 0x8000_0010 with 0xFFFF_FFFF_FFFF_FFFF. Write size=1, addr 0x8000_0012, strobe 0x0C, data 0x0000_0000_ABCD_0000 → read returns 0xFFFF_FFFF_ABCD_FFFF.
- **Errors:**
  - read at 0x7FFF_FFF8 → `resp_err`=1, `resp_data`=0;
  - write size=2 at 0x8000_0002 → `resp_err`=1 and the word is unchanged;
  - read at `BASE`+`WORDS`·8 → `resp_err`=1.
- **`LATENCY`=0 back-to-back:** hold `req_valid` with successive reads → `data_ok` every 2nd cycle. Check that no request is ever captured in a RESP cycle.
- **Reset mid-transaction:** assert `reset`=0 during WAIT of a write to 0x8000_0020 with data 0x55 → outputs go to 0 immediately. After release, a read of 0x8000_0020 returns the prior contents and `txn_count`=0.
- **Protocol violation:** drop `req_valid` and change `req_addr` one cycle after capture → the original transaction still completes at t+1+`LATENCY` with the originally latched address.
